sw_event_servicer: RTL and testbench
====================================

Name: sw_event_servicer

Overview:
- Avalon-MM master that owns the 14-bit switch PIO slave (data, irq_mask and edge_capture registers). It programs the PIO's irq_mask and services its irq.
- On each irq it reads edge_capture, clears it, then reads the live switch level.
- It pushes one {level, edges} event into an internal FIFO, which the fabric drains through a valid/ready port.
- Software no longer needs to take the PIO interrupt.

Parameters:
- WIDTH, 14, switch count; equals the PIO data width.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2 and at least 2.
- DROP_W, 16, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pio_irq  in  1  irq output of the PIO (level).
- avm_address  out  2  PIO register select: 0 = data, 2 = irq_mask, 3 = edge_capture.
- avm_chipselect  out  1  access strobe.
- avm_write_n  out  1  0 = write.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  PIO readdata; registered in the PIO, valid 1 cycle after the address is presented.
- mask_cfg  in  WIDTH  irq mask value to program.
- mask_update  in  1  1-cycle pulse: reprogram the PIO mask from mask_cfg.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accept.
- evt_data  out  2*WIDTH  {level[WIDTH-1:0], edges[WIDTH-1:0]} of the FIFO head.
- busy  out  1  FSM not in IDLE.
- drop_count  out  DROP_W  events lost because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high; clk and reset only, no other enable):
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - evt_valid=0, FIFO emptied, drop_count=0, mask_pending=1.
  - FSM goes to IDLE, so busy=0 in the first cycle after reset.
- Reset asserted mid-sequence aborts any access at the next edge. Partial captures are discarded and the mask is rewritten afterwards.
- FSM states (one cycle each unless noted):
  - IDLE:
    - If mask_pending -> WR_MASK.
    - Else if pio_irq -> RD_EDGE.
    - Else stay.
    - Mask has priority over irq.
  - WR_MASK: chipselect=1, write_n=0, address=2, writedata={0, mask_cfg}. Clear mask_pending -> IDLE.
  - RD_EDGE: chipselect=1, write_n=1, address=3 -> LAT_EDGE.
  - LAT_EDGE: address held at 3, chipselect=0. Latch edges=avm_readdata[WIDTH-1:0] at the end of this cycle -> CLR.
  - CLR: chipselect=1, write_n=0, address=3, writedata=0. This clears all PIO capture bits.
    - If edges==0 (spurious) -> IDLE.
    - Else -> RD_LVL.
  - RD_LVL: address=0, read -> LAT_LVL.
  - LAT_LVL: latch level=avm_readdata[WIDTH-1:0] -> PUSH.
  - PUSH:
    - If the FIFO is not full, write {level, edges}.
    - If full, discard the event and increment drop_count, saturating at all-ones.
    - Then -> IDLE.
- Timing:
  - irq to push: 7 cycles (IDLE sample through PUSH).
  - The next irq is serviced no earlier than 1 cycle after PUSH.
  - avm_chipselect is 1 only in WR_MASK, RD_EDGE, CLR and RD_LVL.
- Clear window: edges that land in the PIO between the RD_EDGE sample and CLR are lost. This is a known one-cycle window and is accepted.
- mask_update while the FSM is busy sets mask_pending. The write happens on the next pass through IDLE. Several pulses collapse into one write of the current mask_cfg value.
- FIFO:
  - First-word-fall-through; evt_data is valid whenever evt_valid=1.
  - A pop occurs when evt_valid and evt_ready are both 1.
  - Push and pop in the same cycle while full: the pop is taken first, so no drop occurs and the count stays FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH; a separate count (log2(FIFO_DEPTH)+1 bits) gives full/empty.
- busy = (state != IDLE).

Test Plan:
- Reset released with mask_cfg=14'h3FFF -> one write cycle (address=2, writedata=32'h3FFF) within 2 cycles; busy returns to 0; evt_valid=0.
- PIO model asserts pio_irq with edge_capture=14'h0005, data=14'h0101 -> reads at address 3, write 0 to address 3, read at address 0. evt_data={14'h0101, 14'h0005} valid exactly 7 cycles after irq is sampled.
- pio_irq asserted with edge_capture reading 0 -> clear write issued, no read at address 0, no push, back to IDLE after CLR.
- evt_ready=0 and 6 irq events with FIFO_DEPTH=4 -> 4 events held, drop_count=2; then evt_ready=1 drains them in order with the original edge values.
- FIFO full, and a PUSH coincides with evt_ready=1 -> no drop; evt_valid stays 1; drop_count is unchanged.
- mask_update pulsed during LAT_EDGE with mask_cfg=14'h00F0 -> the service sequence completes first, then one address-2 write with 14'h00F0. Reset asserted during RD_LVL -> all outputs return to reset values next cycle and the FIFO is empty.

Source files
------------

// File: rtl/sw_event_servicer.sv
// Avalon-MM master that programs the switch PIO irq mask, services its interrupt
// (read edges, clear, read level) and queues {level, edges} events in a FWFT FIFO.
module sw_event_servicer #(
  parameter int WIDTH      = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pio_irq,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  input  logic [WIDTH-1:0]     mask_cfg,
  input  logic                 mask_update,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2*WIDTH-1:0]   evt_data,
  output logic                 busy,
  output logic [DROP_W-1:0]    drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, WR_MASK, RD_EDGE, LAT_EDGE, CLR, RD_LVL, LAT_LVL, PUSH
  } state_t;

  state_t               state, state_nxt;
  logic                 mask_pending;
  logic [WIDTH-1:0]     edges, level;
  logic [2*WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       cnt;
  logic                 full, pop, push_req, push_ok;
  logic                 unused_rd;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign unused_rd = ^avm_readdata[31:WIDTH];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mask_pending <= 1'b1;
    end else begin
      state <= state_nxt;
      // a pulse landing in WR_MASK keeps the request alive for another write
      if (mask_update)
        mask_pending <= 1'b1;
      else if (state == WR_MASK)
        mask_pending <= 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = '0;
    case (state)
      IDLE: begin
        if (mask_pending)  state_nxt = WR_MASK;
        else if (pio_irq)  state_nxt = RD_EDGE;
      end
      WR_MASK: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 2'd2;
        avm_writedata  = {{(32-WIDTH){1'b0}}, mask_cfg};
        state_nxt      = IDLE;
      end
      RD_EDGE: begin
        avm_chipselect = 1'b1;
        avm_address    = 2'd3;
        state_nxt      = LAT_EDGE;
      end
      LAT_EDGE: begin
        avm_address = 2'd3;
        state_nxt   = CLR;
      end
      CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 2'd3;
        state_nxt      = (edges == '0) ? IDLE : RD_LVL;
      end
      RD_LVL: begin
        avm_chipselect = 1'b1;
        state_nxt      = LAT_LVL;
      end
      LAT_LVL: state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // capture registers: readdata is valid in the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (state == LAT_EDGE) edges <= avm_readdata[WIDTH-1:0];
    if (state == LAT_LVL)  level <= avm_readdata[WIDTH-1:0];
  end

  // event FIFO; a simultaneous pop frees the slot for a push when full
  assign full      = cnt[PTR_W];
  assign evt_valid = (cnt != '0);
  assign evt_data  = mem[rd_ptr];
  assign pop       = evt_valid & evt_ready;
  assign push_req  = (state == PUSH);
  assign push_ok   = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {level, edges};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push_req && !push_ok) drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_sw_event_servicer.sv
// Bench for sw_event_servicer: behavioural switch PIO plus an event scoreboard.
module tb_sw_event_servicer;

  localparam int W = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pio_irq;
  logic [1:0]    avm_address;
  logic          avm_chipselect;
  logic          avm_write_n;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic [W-1:0]  mask_cfg = 14'h3FFF;
  logic          mask_update = 1'b0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [2*W-1:0] evt_data;
  logic          busy;
  logic [15:0]   drop_count;

  sw_event_servicer #(.WIDTH(W), .FIFO_DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .pio_irq(pio_irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .mask_cfg(mask_cfg), .mask_update(mask_update),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // PIO model
  logic [W-1:0]  sw_level = '0;
  logic [W-1:0]  cap = '0;
  logic [W-1:0]  pmask = '0;
  logic [31:0]   rdata = '0;
  logic          inject = 1'b0;
  logic [W-1:0]  inject_val = '0;
  logic          irq_force = 1'b0;
  int            n_wr_mask = 0, n_wr_clr = 0, n_rd_edge = 0, n_rd_lvl = 0;
  logic [31:0]   last_mask_wd = '0;

  assign avm_readdata = rdata;
  assign pio_irq = irq_force | (|(cap & pmask));

  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        2'd0: begin rdata <= {18'd0, sw_level}; n_rd_lvl <= n_rd_lvl + 1; end
        2'd2: rdata <= {18'd0, pmask};
        2'd3: begin rdata <= {18'd0, cap}; n_rd_edge <= n_rd_edge + 1; end
        default: rdata <= '0;
      endcase
    end
    if (avm_chipselect && !avm_write_n) begin
      if (avm_address == 2'd2) begin
        pmask <= avm_writedata[W-1:0];
        last_mask_wd <= avm_writedata;
        n_wr_mask <= n_wr_mask + 1;
      end
      if (avm_address == 2'd3) begin
        cap <= '0;
        n_wr_clr <= n_wr_clr + 1;
      end
    end
    if (inject) cap <= cap | inject_val;
  end

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic inject_edges(input logic [W-1:0] v);
    @(negedge clk);
    inject_val = v;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic do_event(input logic [W-1:0] e, input logic [W-1:0] l);
    wait_idle();
    sw_level = l;
    inject_edges(e);
    @(negedge clk);
    wait_idle();
  endtask

  task automatic drain(input int n);
    logic [2*W-1:0] exp;
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      tests++;
      if (evt_valid !== 1'b1 || evt_data !== exp) begin
        fails++;
        $display("FAIL drain[%0d]: valid=%b data=%h, required valid=1 data=%h", i, evt_valid, evt_data, exp);
      end
      @(negedge clk);
    end
    evt_ready = 1'b0;
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: evt_valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_reset();
    int w0;
    reset = 1'b1;
    mask_cfg = 14'h3FFF;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 ||
        avm_address !== 2'd0 || avm_writedata !== 32'd0 || evt_valid !== 1'b0 || drop_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b cs=%b wn=%b addr=%0d wd=%h vld=%b drop=%0d, required 0 0 1 0 0 0 0",
               busy, avm_chipselect, avm_write_n, avm_address, avm_writedata, evt_valid, drop_count);
    end
    w0 = n_wr_mask;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (n_wr_mask !== w0 + 1 || last_mask_wd !== 32'h3FFF) begin
      fails++;
      $display("FAIL reset_mask_write: writes=%0d data=%h, required %0d data=00003fff", n_wr_mask - w0, last_mask_wd, 1);
    end
    tests++;
    if (busy !== 1'b0 || evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b evt_valid=%b, required 0 0", busy, evt_valid);
    end
  endtask

  task automatic test_service();
    int re, rc, rl;
    wait_idle();
    sw_level = 14'h0101;
    re = n_rd_edge; rc = n_wr_clr; rl = n_rd_lvl;
    exp_q.push_back({14'h0101, 14'h0005});
    inject_edges(14'h0005);
    repeat (6) @(negedge clk);
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL service_early: evt_valid=%b at 6 cycles, required 0", evt_valid);
    end
    @(negedge clk);
    tests++;
    if (evt_valid !== 1'b1 || evt_data !== {14'h0101, 14'h0005}) begin
      fails++;
      $display("FAIL service_latency: valid=%b data=%h at 7 cycles, required 1 %h", evt_valid, evt_data, {14'h0101, 14'h0005});
    end
    tests++;
    if (n_rd_edge - re !== 1 || n_wr_clr - rc !== 1 || n_rd_lvl - rl !== 1) begin
      fails++;
      $display("FAIL service_bus: rd3=%0d wr3=%0d rd0=%0d, required 1 1 1", n_rd_edge - re, n_wr_clr - rc, n_rd_lvl - rl);
    end
    drain(1);
  endtask

  task automatic test_spurious();
    int re, rc, rl;
    wait_idle();
    re = n_rd_edge; rc = n_wr_clr; rl = n_rd_lvl;
    irq_force = 1'b1;
    @(negedge clk);
    irq_force = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd3 || avm_writedata !== 32'd0) begin
      fails++;
      $display("FAIL spurious_clr: busy=%b cs=%b wn=%b addr=%0d wd=%h, required 1 1 0 3 0",
               busy, avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL spurious_idle: busy=%b after CLR, required 0", busy);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (n_rd_edge - re !== 1 || n_wr_clr - rc !== 1 || n_rd_lvl - rl !== 0 || evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL spurious_bus: rd3=%0d wr3=%0d rd0=%0d vld=%b, required 1 1 0 0",
               n_rd_edge - re, n_wr_clr - rc, n_rd_lvl - rl, evt_valid);
    end
  endtask

  task automatic test_drop();
    logic [W-1:0] e, l;
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = 14'h0001 << i;
      l = 14'h0100 + 14'(i);
      if (i < 4) exp_q.push_back({l, e});
      do_event(e, l);
    end
    tests++;
    if (drop_count !== 16'd2 || evt_valid !== 1'b1) begin
      fails++;
      $display("FAIL drop_count: drop=%0d valid=%b, required 2 1", drop_count, evt_valid);
    end
    drain(4);
  endtask

  task automatic test_push_while_full();
    logic [2*W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({14'h0200 + 14'(i), 14'h0010 << i});
      do_event(14'h0010 << i, 14'h0200 + 14'(i));
    end
    exp_q.push_back({14'h0333, 14'h0800});
    sw_level = 14'h0333;
    inject_edges(14'h0800);
    repeat (6) @(negedge clk);
    evt_ready = 1'b1;
    exp = exp_q.pop_front();
    tests++;
    if (evt_data !== exp || busy !== 1'b1) begin
      fails++;
      $display("FAIL full_head: data=%h busy=%b, required %h 1", evt_data, busy, exp);
    end
    @(negedge clk);
    evt_ready = 1'b0;
    tests++;
    if (drop_count !== 16'd2 || evt_valid !== 1'b1) begin
      fails++;
      $display("FAIL full_push_pop: drop=%0d valid=%b, required 2 1", drop_count, evt_valid);
    end
    drain(4);
  endtask

  task automatic test_mask_update();
    int w0;
    wait_idle();
    sw_level = 14'h2AAA;
    w0 = n_wr_mask;
    exp_q.push_back({14'h2AAA, 14'h0010});
    inject_edges(14'h0010);
    repeat (2) @(negedge clk);
    mask_cfg = 14'h00F0;
    mask_update = 1'b1;
    @(negedge clk);
    mask_update = 1'b0;
    @(negedge clk);
    mask_update = 1'b1;
    @(negedge clk);
    mask_update = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (n_wr_mask !== w0 || evt_valid !== 1'b1) begin
      fails++;
      $display("FAIL mask_order: writes=%0d valid=%b, required %0d 1", n_wr_mask - w0, evt_valid, 0);
    end
    @(negedge clk);
    tests++;
    if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd2 || avm_writedata !== 32'h00F0) begin
      fails++;
      $display("FAIL mask_write: cs=%b wn=%b addr=%0d wd=%h, required 1 0 2 000000f0",
               avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (n_wr_mask !== w0 + 1 || last_mask_wd !== 32'h00F0) begin
      fails++;
      $display("FAIL mask_collapse: writes=%0d data=%h, required 1 000000f0", n_wr_mask - w0, last_mask_wd);
    end
    drain(1);
  endtask

  task automatic test_reset_mid();
    int w0;
    evt_ready = 1'b0;
    exp_q.push_back({14'h1234, 14'h0040});
    do_event(14'h0040, 14'h1234);
    tests++;
    if (evt_valid !== 1'b1 || evt_data !== {14'h1234, 14'h0040}) begin
      fails++;
      $display("FAIL pre_reset_fifo: valid=%b data=%h, required 1 %h", evt_valid, evt_data, {14'h1234, 14'h0040});
    end
    sw_level = 14'h0555;
    inject_edges(14'h0080);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 2'd0 ||
        avm_writedata !== 32'd0 || evt_valid !== 1'b0 || drop_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b cs=%b wn=%b addr=%0d wd=%h vld=%b drop=%0d, required 0 0 1 0 0 0 0",
               busy, avm_chipselect, avm_write_n, avm_address, avm_writedata, evt_valid, drop_count);
    end
    exp_q.delete();
    w0 = n_wr_mask;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (n_wr_mask !== w0 + 1 || last_mask_wd !== 32'h00F0 || evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_rewrite: writes=%0d data=%h valid=%b, required 1 000000f0 0",
               n_wr_mask - w0, last_mask_wd, evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_service();
    test_spurious();
    test_drop();
    test_push_while_full();
    test_mask_update();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
